// File: rtl/period_meter_pkg.sv
// Shared types for the period meter: FSM state encoding and its width.
package period_meter_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_ABORT = 3'd4
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous input followed by registered
// one-cycle rise/fall strobes taken from the synchronized level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // prev_q holds the previous synchronized bit, so a strobe can never be
    // derived from a possibly metastable first stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], sig_in};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in sysclk cycles,
// single-shot or back-to-back, with an abort when a required edge never arrives.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000000
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             rise, fall;
    logic             timed_out;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk    (sysclk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign timed_out = (cnt_q >= TIMEOUT_C);

    // The timeout check wins over edges, so cnt never climbs past TIMEOUT.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cap_d    = hi_cap_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (timed_out) begin
                    state_d = ST_ABORT;
                end else if (rise) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (timed_out) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (fall) begin
                        hi_cap_d = cnt_q;
                        state_d  = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (timed_out) begin
                    state_d = ST_ABORT;
                end else if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_cap_q;
                    timeout_d   = 1'b0;
                    done_d      = 1'b1;
                    // The closing rise also opens the next period in continuous mode.
                    if (continuous) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ABORT: begin
                period_d    = '0;
                high_time_d = '0;
                timeout_d   = 1'b1;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
                cnt_d       = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Busy covers the done cycle too, which also drops a start that lands on it.
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_cap_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_cap_q    <= hi_cap_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign period    = period_q;
    assign high_time = high_time_q;
    assign timeout   = timeout_q;

endmodule
